// File: rtl/issue_select.sv
// Oldest-first select/grant scheduler for the integer issue queue: per-entry valid, tags, free count.
// Define ISSUE_SELECT_AGE_EN for age-matrix ordering; otherwise lowest index wins (no age flops).
module issue_select #(
    parameter int ISSUE_NUM  = 4,
    parameter int PRF_WIDTH  = 6,
    parameter int CIQ_DEPTH  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ISSUE_NUM-1:0]                 alloc_valid,
    input  logic [ISSUE_NUM-1:0][ADDR_WIDTH-1:0] alloc_addr,
    input  logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]  alloc_prd,
    input  logic [CIQ_DEPTH-1:0]                 entry_rdy,
    input  logic [ISSUE_NUM-1:0]                 port_stall,
    input  logic                                 flush,
    output logic [ISSUE_NUM-1:0]                 arbit_grant,
    output logic [ISSUE_NUM-1:0][ADDR_WIDTH-1:0] arbit_addr,
    output logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]  arbit_prd,
    output logic [CIQ_DEPTH-1:0]                 entry_free,
    output logic [ADDR_WIDTH:0]                  free_cnt
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [CIQ_DEPTH-1:0]                 valid_reg, valid_next;
    logic [PRF_WIDTH-1:0]                 prd_mem [CIQ_DEPTH];
    logic [CIQ_DEPTH-1:0]                 alloc_hit;
    logic [CIQ_DEPTH-1:0]                 remaining, eligible, grant_mask;
    logic [ISSUE_NUM-1:0]                 sel_valid;
    logic [ISSUE_NUM-1:0][ADDR_WIDTH-1:0] sel_addr;
    logic [CNT_W-1:0]                     grant_cnt, alloc_cnt, free_cnt_next;

    logic [ISSUE_NUM-1:0]                 arbit_grant_reg;
    logic [ISSUE_NUM-1:0][ADDR_WIDTH-1:0] arbit_addr_reg;
    logic [ISSUE_NUM-1:0][PRF_WIDTH-1:0]  arbit_prd_reg;
    logic [CIQ_DEPTH-1:0]                 entry_free_reg;
    logic [CNT_W-1:0]                     free_cnt_reg;

`ifdef ISSUE_SELECT_AGE_EN
    localparam int LANE_W = (ISSUE_NUM > 1) ? $clog2(ISSUE_NUM) : 1;
    logic [CIQ_DEPTH-1:0] age_reg [CIQ_DEPTH];
    logic [LANE_W-1:0]    alloc_lane [CIQ_DEPTH];
`endif

    // Decode allocation lanes onto entries; a higher lane hitting the same entry wins.
    always_comb begin
        alloc_hit = '0;
        alloc_cnt = '0;
`ifdef ISSUE_SELECT_AGE_EN
        for (int e = 0; e < CIQ_DEPTH; e++) alloc_lane[e] = '0;
`endif
        for (int p = 0; p < ISSUE_NUM; p++) begin
            if (alloc_valid[p]) begin
                alloc_hit[alloc_addr[p]] = 1'b1;
                alloc_cnt = alloc_cnt + 1'b1;
`ifdef ISSUE_SELECT_AGE_EN
                alloc_lane[alloc_addr[p]] = LANE_W'(p);
`endif
            end
        end
    end

    // Port loop: each unstalled port takes the oldest remaining candidate.
    always_comb begin
        remaining  = valid_reg & entry_rdy;
        eligible   = '0;
        grant_mask = '0;
        sel_valid  = '0;
        sel_addr   = '0;
        grant_cnt  = '0;
        for (int p = 0; p < ISSUE_NUM; p++) begin
`ifdef ISSUE_SELECT_AGE_EN
            for (int i = 0; i < CIQ_DEPTH; i++) begin
                eligible[i] = remaining[i];
                for (int j = 0; j < CIQ_DEPTH; j++) begin
                    if (remaining[j] && age_reg[j][i]) eligible[i] = 1'b0;
                end
            end
`else
            eligible = remaining;
`endif
            if (!port_stall[p]) begin
                for (int i = CIQ_DEPTH - 1; i >= 0; i--) begin
                    if (eligible[i]) begin
                        sel_valid[p] = 1'b1;
                        sel_addr[p]  = ADDR_WIDTH'(i);
                    end
                end
            end
            if (sel_valid[p]) begin
                remaining[sel_addr[p]]  = 1'b0;
                grant_mask[sel_addr[p]] = 1'b1;
                grant_cnt               = grant_cnt + 1'b1;
            end
        end
    end

    assign valid_next    = (valid_reg & ~grant_mask) | alloc_hit;
    assign free_cnt_next = free_cnt_reg + grant_cnt - alloc_cnt;

`ifdef ISSUE_SELECT_AGE_EN
    // A new entry is younger than everything valid before the edge and than lower lanes.
    generate
        for (genvar gi = 0; gi < CIQ_DEPTH; gi++) begin : g_age_row
            logic [CIQ_DEPTH-1:0] age_row_next;
            always_comb begin
                age_row_next = age_reg[gi];
                for (int j = 0; j < CIQ_DEPTH; j++) begin
                    if (alloc_hit[j])
                        age_row_next[j] = alloc_hit[gi] ? (alloc_lane[gi] < alloc_lane[j])
                                                        : valid_reg[gi];
                    else if (alloc_hit[gi])
                        age_row_next[j] = 1'b0;
                end
            end
            always_ff @(posedge clk) begin
                if (rst)
                    age_reg[gi] <= '0;
                else if (!flush)
                    age_reg[gi] <= age_row_next;
            end
        end
    endgenerate
`endif

    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            for (int p = 0; p < ISSUE_NUM; p++) begin
                if (alloc_valid[p]) prd_mem[alloc_addr[p]] <= alloc_prd[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg       <= '0;
            arbit_grant_reg <= '0;
            arbit_addr_reg  <= '0;
            arbit_prd_reg   <= '0;
            entry_free_reg  <= '0;
            free_cnt_reg    <= CNT_W'(CIQ_DEPTH);
        end else if (flush) begin
            valid_reg       <= '0;
            arbit_grant_reg <= '0;
            entry_free_reg  <= '0;
            free_cnt_reg    <= CNT_W'(CIQ_DEPTH);
        end else begin
            valid_reg       <= valid_next;
            arbit_grant_reg <= sel_valid;
            entry_free_reg  <= grant_mask;
            free_cnt_reg    <= free_cnt_next;
            for (int p = 0; p < ISSUE_NUM; p++) begin
                if (sel_valid[p]) begin
                    arbit_addr_reg[p] <= sel_addr[p];
                    arbit_prd_reg[p]  <= prd_mem[sel_addr[p]];
                end
            end
        end
    end

    assign arbit_grant = arbit_grant_reg;
    assign arbit_addr  = arbit_addr_reg;
    assign arbit_prd   = arbit_prd_reg;
    assign entry_free  = entry_free_reg;
    assign free_cnt    = free_cnt_reg;
endmodule

// File: tb/tb_issue_select.sv
// Directed bench for issue_select; expected orders follow ISSUE_SELECT_AGE_EN when it is defined.
module tb_issue_select;
    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        alloc_valid;
    logic [3:0][3:0]   alloc_addr;
    logic [3:0][5:0]   alloc_prd;
    logic [15:0]       entry_rdy;
    logic [3:0]        port_stall;
    logic              flush;
    logic [3:0]        arbit_grant;
    logic [3:0][3:0]   arbit_addr;
    logic [3:0][5:0]   arbit_prd;
    logic [15:0]       entry_free;
    logic [4:0]        free_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    issue_select dut (
        .clk(clk), .rst(rst), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .alloc_prd(alloc_prd), .entry_rdy(entry_rdy), .port_stall(port_stall), .flush(flush),
        .arbit_grant(arbit_grant), .arbit_addr(arbit_addr), .arbit_prd(arbit_prd),
        .entry_free(entry_free), .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

`ifdef ISSUE_SELECT_AGE_EN
    localparam int S3A0 = 9, S3A1 = 3, S3A2 = 12;
    localparam int S4A0 = 5, S4A2 = 4, S4A3 = 3;
    localparam int S4B0 = 2, S4B2 = 1, S4B3 = 0;
    localparam logic [15:0] S4AM = 16'h0038, S4BM = 16'h0007;
    localparam int S6P0 = 5, S6P1 = 2;
`else
    localparam int S3A0 = 3, S3A1 = 9, S3A2 = 12;
    localparam int S4A0 = 0, S4A2 = 1, S4A3 = 2;
    localparam int S4B0 = 3, S4B2 = 4, S4B3 = 5;
    localparam logic [15:0] S4AM = 16'h0007, S4BM = 16'h0038;
    localparam int S6P0 = 2, S6P1 = 5;
`endif

    function automatic logic [5:0] s3_prd(input int a);
        case (a)
            9:       return 6'h21;
            3:       return 6'h13;
            default: return 6'h2C;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d grant=%b addr=%h prd=%h free=%h cnt=%0d",
                 cyc, arbit_grant, arbit_addr, arbit_prd, entry_free, free_cnt);
    endtask

    task automatic set_alloc(input int lane, input logic [3:0] a, input logic [5:0] t);
        alloc_valid[lane] = 1'b1;
        alloc_addr[lane]  = a;
        alloc_prd[lane]   = t;
    endtask

    task automatic clear_alloc();
        alloc_valid = '0;
        alloc_addr  = '0;
        alloc_prd   = '0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; entry_rdy = '0; port_stall = '0;
        clear_alloc();
        tick(); tick();
        rst = 1'b0;
        check("rst_grant", 32'(arbit_grant), 32'h0);
        check("rst_addr", 32'(arbit_addr), 32'h0);
        check("rst_prd", 32'(arbit_prd), 32'h0);
        check("rst_free", 32'(entry_free), 32'h0);
        check("rst_cnt", 32'(free_cnt), 32'd16);

        // Ready with nothing valid grants nothing
        entry_rdy = 16'hFFFF;
        tick();
        check("idle_grant", 32'(arbit_grant), 32'h0);
        check("idle_cnt", 32'(free_cnt), 32'd16);
        entry_rdy = '0;

        // Entries 9, 3, 12 in successive cycles
        set_alloc(0, 4'd9, 6'h21);  tick(); check("s3_cnt1", 32'(free_cnt), 32'd15);
        set_alloc(0, 4'd3, 6'h13);  tick(); check("s3_cnt2", 32'(free_cnt), 32'd14);
        set_alloc(0, 4'd12, 6'h2C); tick(); check("s3_cnt3", 32'(free_cnt), 32'd13);
        check("s3_nogrant", 32'(arbit_grant), 32'h0);
        clear_alloc();
        entry_rdy = 16'hFFFF;
        tick();
        check("s3_grant", 32'(arbit_grant), 32'b0111);
        check("s3_addr0", 32'(arbit_addr[0]), 32'(S3A0));
        check("s3_addr1", 32'(arbit_addr[1]), 32'(S3A1));
        check("s3_addr2", 32'(arbit_addr[2]), 32'(S3A2));
        check("s3_addr3_hold", 32'(arbit_addr[3]), 32'h0);
        check("s3_prd0", 32'(arbit_prd[0]), 32'(s3_prd(S3A0)));
        check("s3_prd1", 32'(arbit_prd[1]), 32'(s3_prd(S3A1)));
        check("s3_prd2", 32'(arbit_prd[2]), 32'(s3_prd(S3A2)));
        check("s3_free", 32'(entry_free), 32'h1208);
        check("s3_cnt", 32'(free_cnt), 32'd16);
        tick();
        check("s3_after_grant", 32'(arbit_grant), 32'h0);
        check("s3_after_free", 32'(entry_free), 32'h0);
        check("s3_addr0_hold", 32'(arbit_addr[0]), 32'(S3A0));
        entry_rdy = '0;

        // Six entries allocated youngest-index-first, port 1 stalled
        set_alloc(0, 4'd5, 6'h35); set_alloc(1, 4'd4, 6'h34);
        set_alloc(2, 4'd3, 6'h33); set_alloc(3, 4'd2, 6'h32);
        tick();
        clear_alloc();
        set_alloc(0, 4'd1, 6'h31); set_alloc(1, 4'd0, 6'h30);
        tick();
        check("s4_cnt_alloc", 32'(free_cnt), 32'd10);
        clear_alloc();
        entry_rdy = 16'hFFFF;
        port_stall = 4'b0010;
        tick();
        check("s4a_grant", 32'(arbit_grant), 32'b1101);
        check("s4a_addr0", 32'(arbit_addr[0]), 32'(S4A0));
        check("s4a_addr2", 32'(arbit_addr[2]), 32'(S4A2));
        check("s4a_addr3", 32'(arbit_addr[3]), 32'(S4A3));
        check("s4a_prd3", 32'(arbit_prd[3]), 32'(6'h30 + 6'(S4A3)));
        check("s4a_addr1_hold", 32'(arbit_addr[1]), 32'(S3A1));
        check("s4a_free", 32'(entry_free), 32'(S4AM));
        check("s4a_cnt", 32'(free_cnt), 32'd13);
        tick();
        check("s4b_grant", 32'(arbit_grant), 32'b1101);
        check("s4b_addr0", 32'(arbit_addr[0]), 32'(S4B0));
        check("s4b_addr2", 32'(arbit_addr[2]), 32'(S4B2));
        check("s4b_addr3", 32'(arbit_addr[3]), 32'(S4B3));
        check("s4b_prd0", 32'(arbit_prd[0]), 32'(6'h30 + 6'(S4B0)));
        check("s4b_free", 32'(entry_free), 32'(S4BM));
        check("s4b_cnt", 32'(free_cnt), 32'd16);
        port_stall = '0;
        entry_rdy = '0;

        // Single entry via lane 2, ready held for three cycles
        set_alloc(2, 4'd7, 6'h07);
        tick();
        check("s5_cnt_alloc", 32'(free_cnt), 32'd15);
        clear_alloc();
        entry_rdy = 16'h0080;
        tick();
        check("s5_grant", 32'(arbit_grant), 32'b0001);
        check("s5_addr0", 32'(arbit_addr[0]), 32'd7);
        check("s5_prd0", 32'(arbit_prd[0]), 32'h07);
        check("s5_free", 32'(entry_free), 32'h0080);
        check("s5_cnt", 32'(free_cnt), 32'd16);
        tick();
        check("s5_grant2", 32'(arbit_grant), 32'h0);
        check("s5_free2", 32'(entry_free), 32'h0);
        tick();
        check("s5_grant3", 32'(arbit_grant), 32'h0);
        check("s5_cnt3", 32'(free_cnt), 32'd16);
        entry_rdy = '0;

        // Two lanes in one cycle: lane 0 is older
        set_alloc(0, 4'd5, 6'h25); set_alloc(1, 4'd2, 6'h22);
        tick();
        check("s6_cnt_alloc", 32'(free_cnt), 32'd14);
        clear_alloc();
        entry_rdy = 16'hFFFF;
        tick();
        check("s6_grant", 32'(arbit_grant), 32'b0011);
        check("s6_addr0", 32'(arbit_addr[0]), 32'(S6P0));
        check("s6_addr1", 32'(arbit_addr[1]), 32'(S6P1));
        check("s6_prd1", 32'(arbit_prd[1]), (S6P1 == 5) ? 32'h25 : 32'h22);
        check("s6_free", 32'(entry_free), 32'h0024);

        // Reallocate entry 5 while its free pulse is visible
        set_alloc(0, 4'd5, 6'h15);
        tick();
        check("s7_nogrant", 32'(arbit_grant), 32'h0);
        check("s7_cnt", 32'(free_cnt), 32'd15);
        clear_alloc();
        tick();
        check("s7_grant", 32'(arbit_grant), 32'b0001);
        check("s7_addr0", 32'(arbit_addr[0]), 32'd5);
        check("s7_prd0", 32'(arbit_prd[0]), 32'h15);
        check("s7_free", 32'(entry_free), 32'h0020);
        check("s7_cnt2", 32'(free_cnt), 32'd16);
        entry_rdy = '0;

        // Flush alongside allocations and ready entries
        set_alloc(0, 4'd10, 6'h0A); set_alloc(1, 4'd11, 6'h0B);
        tick();
        check("s8_cnt_alloc", 32'(free_cnt), 32'd14);
        clear_alloc();
        set_alloc(0, 4'd12, 6'h0C); set_alloc(1, 4'd13, 6'h0D);
        entry_rdy = 16'hFFFF;
        flush = 1'b1;
        tick();
        check("s8_grant", 32'(arbit_grant), 32'h0);
        check("s8_free", 32'(entry_free), 32'h0);
        check("s8_cnt", 32'(free_cnt), 32'd16);
        flush = 1'b0;
        clear_alloc();
        tick();
        check("s8_grant2", 32'(arbit_grant), 32'h0);
        check("s8_cnt2", 32'(free_cnt), 32'd16);
        tick();
        check("s8_grant3", 32'(arbit_grant), 32'h0);
        check("s8_free3", 32'(entry_free), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/issue_select.md
# issue_select

Select/grant scheduler for the integer issue queue (CIQ). Each cycle it picks up to ISSUE_NUM ready entries, oldest first, one per issue port, and drives the registered grant, entry address and destination tag. The wake-up logic turns those tags into source-ready bits, and the CIQ uses them to read out and release entries. The block holds per-entry valid bits, an age matrix and a free-entry counter.

## Interface
- ISSUE_NUM, 4, issue ports (= allocation lanes)
- PRF_WIDTH, 6, physical register tag width
- CIQ_DEPTH, 16, queue entries
- ADDR_WIDTH, 4, entry index width (2^ADDR_WIDTH = CIQ_DEPTH)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- alloc_valid  in  ISSUE_NUM  per-lane allocate request
- alloc_addr  in  ADDR_WIDTH x ISSUE_NUM  target entry per lane
- alloc_prd  in  PRF_WIDTH x ISSUE_NUM  destination tag stored with the entry
- entry_rdy  in  CIQ_DEPTH  both sources ready (from wake-up)
- port_stall  in  ISSUE_NUM  issue port p cannot accept this cycle
- flush  in  1  kill all entries
- arbit_grant  out  ISSUE_NUM  port p issues this cycle (registered)
- arbit_addr  out  ADDR_WIDTH x ISSUE_NUM  granted entry per port (registered)
- arbit_prd  out  PRF_WIDTH x ISSUE_NUM  granted destination tag per port (registered)
- entry_free  out  CIQ_DEPTH  one-cycle pulse, entry released (registered)
- free_cnt  out  ADDR_WIDTH+1  number of invalid entries (registered)

## Operation
- Storage: valid[CIQ_DEPTH], prd[CIQ_DEPTH], age[i][j] (1 = i older than j).
- Allocate (lane p with alloc_valid[p]=1), at the clock edge:
  - valid[a] is set, prd[a] is written and row age[a] is cleared.
  - column age[*][a] is set for every entry valid before the edge.
  - Within one cycle, lower lanes are older than higher lanes.
- Candidates: C = valid & entry_rdy.
- Port loop p = 0..ISSUE_NUM-1, in order:
  - If port_stall[p]=1, port p grants nothing and consumes no candidate.
  - Otherwise port p picks the oldest entry in C not taken by a lower port: the entry with no older member in the remaining set.
  - If the remaining set is empty, the grant is 0.
- Grant, at the edge: arbit_grant/addr/prd are registered. valid of each granted entry is cleared and its entry_free bit pulses for one cycle. An entry can never be granted twice.
- free_cnt(next) = free_cnt + granted count − allocated count. It is exact and saturates at neither end, because legal traffic cannot over- or underflow it.
- Flush, at the edge: all valid bits are cleared, arbit_grant is 0, entry_free is 0 and free_cnt becomes CIQ_DEPTH. Allocations in the flush cycle are dropped. Flush has priority over allocate and grant.
- Allocation to an already-valid entry is illegal. The block overwrites the entry, it becomes youngest, and free_cnt is still decremented.
- Allocating into an entry in the same cycle its entry_free pulse is visible is legal. That entry is youngest.
- Age values of invalid entries are don't-care. They are masked by valid.

## Timing
- Reset values: arbit_grant=0, arbit_addr=0, arbit_prd=0, entry_free=0, free_cnt=CIQ_DEPTH. All valid bits and all age bits are 0.
- The select path is combinational from entry_rdy/valid/age/port_stall. The outputs are flops, so latency is 1 cycle: entry_rdy at cycle N gives arbit_grant at N+1.
- An entry allocated at edge T is a candidate from cycle T onward. The earliest grant appears after edge T+1.
- arbit_addr and arbit_prd hold their last value when the matching arbit_grant bit is 0.
- Back-to-back issue of independent entries is possible every cycle. There is no bubble.

## Configuration
- ISSUE_SELECT_AGE_EN defined: age-matrix oldest-first selection, as above.
- ISSUE_SELECT_AGE_EN undefined:
  - The age matrix is not built; no age flops.
  - Port p picks the lowest-index remaining candidate (fixed priority).
  - All other behaviour and all timing are identical.

## Test plan
- Reset, then idle: all outputs 0 and free_cnt=16. No grant while entry_rdy=all-ones with no valid entries.
- Allocate entries 9, 3, 12 in successive cycles, then set entry_rdy=all-ones:
  - With AGE_EN: next cycle ports 0..2 grant 9, 3, 12 with their prd tags; entry_free has bits 9, 3, 12 set; free_cnt goes 13 → 16.
  - Without AGE_EN: order is 3, 9, 12.
- 6 ready entries, port_stall=4'b0010: grants on ports 0, 2, 3 only (3 oldest). The remaining 3 are granted the following cycle.
- Single entry with entry_rdy held high for 3 cycles: exactly one grant pulse and one entry_free pulse.
- Allocate in lanes 0 and 1 in the same cycle (entries 5 and 2), both ready: 5 goes to port 0 and 2 goes to port 1 (AGE_EN).
- Flush in the same cycle as 2 allocations and 2 ready entries: next cycle no grants, free_cnt=16 and no later grants.
